// File: rtl/bram_port_arbiter_if.sv
// ============================================================================
//  Module      : bram_port_arbiter_if
//  Description : Bundles the two burst-requester command/data channels, the
//                shared read-data return and the BRAM controller port.
//                The slave modport is the arbiter's view; the master modport is
//                the view of the requesters and the BRAM together.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  // Requester 0
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [LEN_W-1:0]  m0_len;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_wnext;
  logic              m0_rvalid;
  logic              m0_done;
  // Requester 1
  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [LEN_W-1:0]  m1_len;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_wnext;
  logic              m1_rvalid;
  logic              m1_done;
  // Shared read data
  logic [DATA_W-1:0] rdata;
  // BRAM controller port
  logic                bram_en;
  logic [DATA_W/8-1:0] bram_we;
  logic [ADDR_W-1:0]   bram_addr;
  logic [DATA_W-1:0]   bram_dout;
  logic [DATA_W-1:0]   bram_din;
  logic                bram_rst;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_len, m0_wdata,
    output m0_gnt, m0_wnext, m0_rvalid, m0_done,
    input  m1_req, m1_wr, m1_addr, m1_len, m1_wdata,
    output m1_gnt, m1_wnext, m1_rvalid, m1_done,
    output rdata,
    output bram_en, bram_we, bram_addr, bram_dout, bram_rst,
    input  bram_din
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_len, m0_wdata,
    input  m0_gnt, m0_wnext, m0_rvalid, m0_done,
    output m1_req, m1_wr, m1_addr, m1_len, m1_wdata,
    input  m1_gnt, m1_wnext, m1_rvalid, m1_done,
    input  rdata,
    input  bram_en, bram_we, bram_addr, bram_dout, bram_rst,
    output bram_din
  );
endinterface

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
//  Module      : bram_port_arbiter
//  Description : Shares one 32-bit BRAM controller port between two burst
//                requesters. A granted burst runs to completion: word-stepped
//                addresses, write data pulled with wnext, read data returned
//                with a per-requester rvalid RD_LAT cycles after each beat.
//                Default arbitration is round-robin; defining the macro
//                BRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
//                wins every tie).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1    // legal range 1..3
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  bram_port_arbiter_if.slave     bus
);

  localparam int c_BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;      // 0 = requester 0, 1 = requester 1
  logic                wr_q, wr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;          // beats left in BURST, wait cycles in DRAIN
`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic                last_grant_q, last_grant_d;
`endif

  logic                bram_en_q, bram_en_d;
  logic [c_BE_W-1:0]   bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_dout_q, bram_dout_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                wnext0_q, wnext0_d, wnext1_q, wnext1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic [RD_LAT-1:0]   rv0_q, rv0_d, rv1_q, rv1_d;

  logic                w_any_req;
  logic                w_pick;                // winning requester index
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W-1:0]   w_cur_wdata;
  logic                w_rd_issue0, w_rd_issue1;

  // Arbitration and selection of the winning command.
  always_comb begin
    w_any_req = bus.m0_req | bus.m1_req;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    w_pick = ~bus.m0_req;
`else
    if (bus.m0_req && bus.m1_req) begin
      w_pick = ~last_grant_q;
    end else begin
      w_pick = ~bus.m0_req;
    end
`endif
    w_sel_wr    = w_pick ? bus.m1_wr    : bus.m0_wr;
    w_sel_addr  = w_pick ? bus.m1_addr  : bus.m0_addr;
    w_sel_len   = w_pick ? bus.m1_len   : bus.m0_len;
    w_sel_wdata = w_pick ? bus.m1_wdata : bus.m0_wdata;
    w_cur_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;
  end

  // Next-state and registered-output logic of the burst sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    bram_en_d   = 1'b0;
    bram_we_d   = '0;
    bram_addr_d = bram_addr_q;
    bram_dout_d = '0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    wnext0_d    = 1'b0;
    wnext1_d    = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          owner_d = w_pick;
          wr_d    = w_sel_wr;
`ifndef BRAM_ARB_FIXED_PRIO_EN
          last_grant_d = w_pick;
`endif
          gnt0_d  = ~w_pick;
          gnt1_d  = w_pick;
          if (w_sel_len == '0) begin
            state_d = S_DONE;
          end else begin
            // Beat 0 goes out on the same edge as the grant.
            bram_en_d   = 1'b1;
            bram_we_d   = w_sel_wr ? {c_BE_W{1'b1}} : '0;
            bram_addr_d = w_sel_addr;
            bram_dout_d = w_sel_wr ? w_sel_wdata : '0;
            wnext0_d    = w_sel_wr & ~w_pick;
            wnext1_d    = w_sel_wr & w_pick;
            cnt_d       = w_sel_len - LEN_W'(1);
            if (w_sel_len == LEN_W'(1)) begin
              // Single-beat burst: beat 0 is also the last one.
              state_d = w_sel_wr ? S_DONE : S_DRAIN;
              cnt_d   = LEN_W'(RD_LAT - 1);
            end else begin
              state_d = S_BURST;
            end
          end
        end
      end

      S_BURST: begin
        bram_en_d   = 1'b1;
        bram_we_d   = wr_q ? {c_BE_W{1'b1}} : '0;
        bram_addr_d = bram_addr_q + ADDR_W'(4);
        bram_dout_d = wr_q ? w_cur_wdata : '0;
        wnext0_d    = wr_q & ~owner_q;
        wnext1_d    = wr_q & owner_q;
        cnt_d       = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          // Writes finish with the last beat; reads wait for the return pipe.
          state_d = wr_q ? S_DONE : S_DRAIN;
          cnt_d   = LEN_W'(RD_LAT - 1);
        end
      end

      S_DRAIN: begin
        // Reads are gapless, so the last word appears a fixed time after the
        // last beat; leave as soon as it is being presented.
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end

      S_DONE: begin
        done0_d = ~owner_q;
        done1_d = owner_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A read beat on the bus enters the owner's return pipe on the next edge.
  assign w_rd_issue0 = bram_en_q & (bram_we_q == '0) & ~owner_q;
  assign w_rd_issue1 = bram_en_q & (bram_we_q == '0) & owner_q;

  generate
    if (RD_LAT == 1) begin : g_rv_lat1
      assign rv0_d = w_rd_issue0;
      assign rv1_d = w_rd_issue1;
    end else begin : g_rv_latn
      assign rv0_d = {rv0_q[RD_LAT-2:0], w_rd_issue0};
      assign rv1_d = {rv1_q[RD_LAT-2:0], w_rd_issue1};
    end
  endgenerate

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_dout_q  <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      wnext0_q     <= 1'b0;
      wnext1_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rv0_q        <= '0;
      rv1_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_dout_q  <= bram_dout_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      wnext0_q     <= wnext0_d;
      wnext1_q     <= wnext1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rv0_q        <= rv0_d;
      rv1_q        <= rv1_d;
    end
  end

  assign bus.m0_gnt    = gnt0_q;
  assign bus.m1_gnt    = gnt1_q;
  assign bus.m0_wnext  = wnext0_q;
  assign bus.m1_wnext  = wnext1_q;
  assign bus.m0_done   = done0_q;
  assign bus.m1_done   = done1_q;
  assign bus.m0_rvalid = rv0_q[RD_LAT-1];
  assign bus.m1_rvalid = rv1_q[RD_LAT-1];

  // The BRAM output is already registered and lines up with rvalid, so it is
  // forwarded directly; it is forced to 0 whenever no read word is presented.
  assign bus.rdata = (rv0_q[RD_LAT-1] | rv1_q[RD_LAT-1]) ? bus.bram_din : '0;

  assign bus.bram_en   = bram_en_q;
  assign bus.bram_we   = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_dout = bram_dout_q;
  assign bus.bram_rst  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
//  Module      : tb_bram_port_arbiter
//  Description : Directed self-checking bench for bram_port_arbiter with a
//                one-cycle-latency BRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;

  logic clk;
  logic rst_n;
  logic preload;
  int   n_checks;
  int   n_errors;

  bram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) bus ();

  bram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .RD_LAT(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: 256 words, one-cycle registered read.
  logic [31:0] mem [0:255];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 4; k++) mem[64 + k] <= 32'hA0 + 32'(k);
    end else if (bus.bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.bram_we[b]) mem[bus.bram_addr[9:2]][8*b +: 8] <= bus.bram_dout[8*b +: 8];
      rd_q <= mem[bus.bram_addr[9:2]];
    end
  end
  assign bus.bram_din = rd_q;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input bit which, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      seen = which ? bus.m1_done : bus.m0_done;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0] wrap_exp [4];
  bit          exp_gnt0, exp_gnt1, exp_en, exp_done0, exp_done1, own;
  int          b, p;

  initial begin
    n_checks = 0;
    n_errors = 0;
    preload  = 1'b1;
    rst_n    = 1'b0;
    bus.m0_req = 0; bus.m0_wr = 0; bus.m0_addr = '0; bus.m0_len = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_wr = 0; bus.m1_addr = '0; bus.m1_len = '0; bus.m1_wdata = '0;
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    step();
    step();
    preload = 1'b0;
    // Reset state
    check("rst_en",   bus.bram_en,   1'b0);
    check("rst_we",   bus.bram_we,   4'h0);
    check("rst_addr", bus.bram_addr, 32'h0);
    check("rst_gnt",  {bus.m0_gnt, bus.m1_gnt}, 2'b00);
    check("rst_done", {bus.m0_done, bus.m1_done}, 2'b00);
    check("rst_brst", bus.bram_rst,  1'b0);
    rst_n = 1'b1;
    step();

    // Single read: m0, 0x100, len 4
    bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = 32'h100; bus.m0_len = 16'd4;
    step();
    check("rd_gnt", bus.m0_gnt, 1'b1);
    check("rd_gnt1_quiet", bus.m1_gnt, 1'b0);
    bus.m0_req = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd_en%0d", k), bus.bram_en, 1'b1);
      check($sformatf("rd_we%0d", k), bus.bram_we, 4'h0);
      check($sformatf("rd_addr%0d", k), bus.bram_addr, 32'h100 + 32'(4 * k));
      check($sformatf("rd_m1rv%0d", k), bus.m1_rvalid, 1'b0);
      if (k > 0) begin
        check($sformatf("rd_rv%0d", k - 1), bus.m0_rvalid, 1'b1);
        check($sformatf("rd_data%0d", k - 1), bus.rdata, 32'hA0 + 32'(k - 1));
      end else begin
        check("rd_rv_early", bus.m0_rvalid, 1'b0);
      end
      step();
    end
    check("rd_en_off", bus.bram_en, 1'b0);
    check("rd_rv3", bus.m0_rvalid, 1'b1);
    check("rd_data3", bus.rdata, 32'hA3);
    check("rd_done_early", bus.m0_done, 1'b0);
    step();
    check("rd_done", bus.m0_done, 1'b1);
    check("rd_rv_end", bus.m0_rvalid, 1'b0);
    step();
    check("rd_done_pulse", bus.m0_done, 1'b0);

    // Write: m1, 0x40, len 3, data 11/22/33
    bus.m1_req = 1; bus.m1_wr = 1; bus.m1_addr = 32'h40; bus.m1_len = 16'd3; bus.m1_wdata = 32'h11;
    step();
    check("wr_gnt", bus.m1_gnt, 1'b1);
    bus.m1_req = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wr_we%0d", k), bus.bram_we, 4'hF);
      check($sformatf("wr_addr%0d", k), bus.bram_addr, 32'h40 + 32'(4 * k));
      check($sformatf("wr_dout%0d", k), bus.bram_dout, 32'h11 * 32'(k + 1));
      check($sformatf("wr_wnext%0d", k), bus.m1_wnext, 1'b1);
      check($sformatf("wr_m0wnext%0d", k), bus.m0_wnext, 1'b0);
      bus.m1_wdata = 32'h11 * 32'(k + 2);
      step();
    end
    check("wr_we_off", bus.bram_we, 4'h0);
    check("wr_wnext_off", bus.m1_wnext, 1'b0);
    check("wr_done", bus.m1_done, 1'b1);
    check("wr_m0done", bus.m0_done, 1'b0);
    step();
    check("wr_mem0", mem[16], 32'h11);
    check("wr_mem1", mem[17], 32'h22);
    check("wr_mem2", mem[18], 32'h33);

    // Zero length
    bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = 32'h100; bus.m0_len = 16'd0;
    step();
    check("z_gnt", bus.m0_gnt, 1'b1);
    check("z_en0", bus.bram_en, 1'b0);
    bus.m0_req = 0;
    step();
    check("z_done", bus.m0_done, 1'b1);
    check("z_en1", bus.bram_en, 1'b0);
    step();
    check("z_en2", bus.bram_en, 1'b0);

    // Address wrap
    bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = 32'hFFFF_FFF8; bus.m0_len = 16'd4;
    step();
    bus.m0_req = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_addr%0d", k), bus.bram_addr, wrap_exp[k]);
      step();
    end
    wait_done("wrap_done", 1'b0, 8);
    step();

    // Contention from reset: both held, len-2 writes
    apply_reset();
    bus.m0_req = 1; bus.m0_wr = 1; bus.m0_addr = 32'h200; bus.m0_len = 16'd2; bus.m0_wdata = 32'h5A;
    bus.m1_req = 1; bus.m1_wr = 1; bus.m1_addr = 32'h300; bus.m1_len = 16'd2; bus.m1_wdata = 32'hA5;
    for (int c = 0; c < 12; c++) begin
      step();
      b = c / 3;
      p = c % 3;
`ifdef BRAM_ARB_FIXED_PRIO_EN
      own = 1'b0;
`else
      own = b[0];
`endif
      exp_gnt0  = (p == 0) && !own;
      exp_gnt1  = (p == 0) && own;
      exp_en    = (p != 2);
      exp_done0 = (p == 2) && !own;
      exp_done1 = (p == 2) && own;
      check($sformatf("ct_gnt0_c%0d", c),  bus.m0_gnt,  exp_gnt0);
      check($sformatf("ct_gnt1_c%0d", c),  bus.m1_gnt,  exp_gnt1);
      check($sformatf("ct_en_c%0d", c),    bus.bram_en, exp_en);
      check($sformatf("ct_done0_c%0d", c), bus.m0_done, exp_done0);
      check($sformatf("ct_done1_c%0d", c), bus.m1_done, exp_done1);
    end
    bus.m0_req = 0;
    bus.m1_req = 0;
    step();
    step();

    // Reset mid-burst: len-8 read, reset during beat 2
    bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = 32'h100; bus.m0_len = 16'd8;
    step();
    bus.m0_req = 0;
    step();
    step();
    check("mr_beat2_addr", bus.bram_addr, 32'h108);
    rst_n = 1'b0;
    #1;
    check("mr_en",   bus.bram_en,   1'b0);
    check("mr_addr", bus.bram_addr, 32'h0);
    check("mr_rv",   bus.m0_rvalid, 1'b0);
    check("mr_rdata", bus.rdata,    32'h0);
    check("mr_done", bus.m0_done,   1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("mr_nodone%0d", c), bus.m0_done, 1'b0);
      check($sformatf("mr_idle%0d", c),   bus.bram_en, 1'b0);
    end
    bus.m1_req = 1; bus.m1_wr = 0; bus.m1_addr = 32'h100; bus.m1_len = 16'd1;
    step();
    check("mr_m1_gnt", bus.m1_gnt, 1'b1);
    check("mr_m0_gnt", bus.m0_gnt, 1'b0);
    check("mr_m1_addr", bus.bram_addr, 32'h100);
    bus.m1_req = 0;
    step();
    check("mr_m1_rv", bus.m1_rvalid, 1'b1);
    check("mr_m1_data", bus.rdata, 32'hA0);
    step();
    check("mr_m1_done", bus.m1_done, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
